// File: rtl/event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : event_encoder
// Purpose  : Front end of the recorder's 16-bit input-event bus. Synchronizes
//            and debounces the four push-buttons, samples the slide switches,
//            and runs the transport state machine. Each accepted press becomes
//            a single-cycle event word {code[3:0], speed[1:0], param[3:0],
//            inter, 5'b0}.
// Ports    : i_clk    - system clock (50 MHz)
//            i_rst    - asynchronous active-low reset
//            i_key_n  - raw push-buttons, active-low
//                       (0 RECORD, 1 PLAY/PAUSE, 2 STOP, 3 SET_SPEED)
//            i_sw     - raw slide switches ([3:0] param, [5:4] speed, [6] inter)
//            i_stop   - one-cycle end-of-playback/record pulse, forces IDLE
//            o_event  - registered event word, zero when no event
//            o_state  - registered transport state
//                       (00 IDLE, 01 RECORDING, 10 PLAYING, 11 PAUSED)
// Options  : KEY_DEBOUNCE_EN - when defined, each key uses a counter-based
//            debouncer of DEBOUNCE_CYCLES; otherwise the synchronized level is
//            registered once.
// Revision : 1.0 - initial release
// ============================================================================
module event_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_key_n,
    input  logic [6:0]  i_sw,
    input  logic        i_stop,
    output logic [15:0] o_event,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REC   = 2'b01,
        S_PLAY  = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    localparam int         C_KEY_RECORD = 0;
    localparam int         C_KEY_PLAY   = 1;
    localparam int         C_KEY_STOP   = 2;
    localparam int         C_KEY_SPEED  = 3;

    localparam logic [3:0] C_CODE_NONE   = 4'd0;
    localparam logic [3:0] C_CODE_RECORD = 4'd1;
    localparam logic [3:0] C_CODE_PLAY   = 4'd2;
    localparam logic [3:0] C_CODE_PAUSE  = 4'd3;
    localparam logic [3:0] C_CODE_STOP   = 4'd4;
    localparam logic [3:0] C_CODE_SPEED  = 4'd5;

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("event_encoder: DEBOUNCE_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Two-flop synchronizers. Keys reset to released (1).
    // r_sync_vld marks when r_key_s2 carries a real input sample rather
    // than the reset value, so the arming logic below is not fooled.
    // ------------------------------------------------------------------
    logic [3:0] r_key_s1, r_key_s2;
    logic [6:0] r_sw_s1,  r_sw_s2;
    logic [1:0] r_sync_vld;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_key_s1   <= '1;
            r_key_s2   <= '1;
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
            r_sync_vld <= '0;
        end else begin
            r_key_s1   <= i_key_n;
            r_key_s2   <= r_key_s1;
            r_sw_s1    <= i_sw;
            r_sw_s2    <= r_sw_s1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Per-key debounced level
    // ------------------------------------------------------------------
    logic [3:0] w_deb;

    for (genvar k = 0; k < 4; k++) begin : g_key
`ifdef KEY_DEBOUNCE_EN
        localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] r_cnt;
        logic             r_lvl;

        // The counter holds the number of consecutive mismatching samples
        // already seen; the level flips on the DEBOUNCE_CYCLES-th one.
        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_cnt <= '0;
                r_lvl <= 1'b1;
            end else if (r_key_s2[k] != r_lvl) begin
                if (r_cnt == C_CNT_LAST) begin
                    r_lvl <= r_key_s2[k];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
`else
        logic r_lvl;

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_lvl <= 1'b1;
            end else begin
                r_lvl <= r_key_s2[k];
            end
        end
`endif
        assign w_deb[k] = r_lvl;
    end

    // ------------------------------------------------------------------
    // Press detection. A key is armed only after it has been seen released
    // following reset, so a key held through reset never yields a press.
    // ------------------------------------------------------------------
    logic [3:0] r_deb_q;
    logic [3:0] r_armed;
    logic [3:0] w_press;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_deb_q <= '1;
            r_armed <= '0;
        end else begin
            r_deb_q <= w_deb;
            if (r_sync_vld[1]) begin
                r_armed <= r_armed | r_key_s2;
            end
        end
    end

    assign w_press = r_deb_q & ~w_deb & r_armed;

    // ------------------------------------------------------------------
    // Transport state machine
    // ------------------------------------------------------------------
    state_t      r_state, w_state_nxt;
    logic [15:0] r_event, w_event_nxt;
    logic [3:0]  w_code;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_event <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_event <= w_event_nxt;
        end
    end

    // Priority: i_stop, then STOP > RECORD > PLAY/PAUSE > SET_SPEED, where
    // only presses legal in the current state compete. Losers are dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_code      = C_CODE_NONE;
        if (i_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_press[C_KEY_STOP] && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_code      = C_CODE_STOP;
        end else if (w_press[C_KEY_RECORD] && (r_state == S_IDLE)) begin
            w_state_nxt = S_REC;
            w_code      = C_CODE_RECORD;
        end else if (w_press[C_KEY_PLAY] && (r_state != S_REC)) begin
            if (r_state == S_PLAY) begin
                w_state_nxt = S_PAUSE;
                w_code      = C_CODE_PAUSE;
            end else begin
                w_state_nxt = S_PLAY;
                w_code      = C_CODE_PLAY;
            end
        end else if (w_press[C_KEY_SPEED]) begin
            w_code = C_CODE_SPEED;
        end

        w_event_nxt = '0;
        if (w_code != C_CODE_NONE) begin
            w_event_nxt = {w_code, r_sw_s2[5:4], r_sw_s2[3:0], r_sw_s2[6], 5'b0};
        end
    end

    assign o_event = r_event;
    assign o_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_encoder
// Purpose  : Self-checking bench for event_encoder (DEBOUNCE_CYCLES = 4).
//            A behavioural model predicts every event word, its cycle and the
//            transport state; a monitor pops predictions as the DUT emits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_encoder;

    localparam int D = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int WIN = D;
`else
    localparam int WIN = 1;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_n = 4'hF;
    logic [6:0]  sw    = 7'h0;
    logic        stop  = 1'b0;
    logic [15:0] o_event;
    logic [1:0]  o_state;

    event_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_key_n (key_n),
        .i_sw    (sw),
        .i_stop  (stop),
        .o_event (o_event),
        .o_state (o_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [15:0] ev;
        logic [1:0]  st;
    } exp_t;

    exp_t       q[$];
    int         cyc;
    logic [3:0] hist_k[$];
    logic [6:0] hist_sw[$];
    logic [3:0] m_deb, m_armed, m_press;
    logic [1:0] m_state;

    localparam logic [1:0] ST_IDLE = 2'b00, ST_REC = 2'b01, ST_PLAY = 2'b10, ST_PAUSE = 2'b11;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        hist_k.delete();
        hist_sw.delete();
        for (int i = 0; i < 16; i++) begin
            hist_k.push_back(4'hF);
            hist_sw.push_back(7'h0);
        end
        m_deb   = 4'hF;
        m_armed = 4'h0;
        m_press = 4'h0;
        m_state = ST_IDLE;
        q.delete();
        cyc = 0;
    endtask

    task automatic model_step();
        int         order[4] = '{2, 0, 1, 3};
        logic [3:0] code;
        logic [1:0] nst;
        logic [6:0] s;
        logic [3:0] h;
        logic [3:0] newpress;
        bit         all_diff;
        exp_t       e;
        cyc++;
        code = 4'd0;
        nst  = m_state;
        if (stop) begin
            nst = ST_IDLE;
        end else begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = order[i];
                if (code == 4'd0 && m_press[k]) begin
                    case (k)
                        2: if (m_state != ST_IDLE) begin code = 4'd4; nst = ST_IDLE; end
                        0: if (m_state == ST_IDLE) begin code = 4'd1; nst = ST_REC; end
                        1: if (m_state == ST_IDLE || m_state == ST_PAUSE) begin
                               code = 4'd2; nst = ST_PLAY;
                           end else if (m_state == ST_PLAY) begin
                               code = 4'd3; nst = ST_PAUSE;
                           end
                        default: code = 4'd5;
                    endcase
                end
            end
        end
        s = hist_sw[$-1];
        if (code != 4'd0) begin
            e.cyc = cyc;
            e.ev  = {code, s[5:4], s[3:0], s[6], 5'b0};
            e.st  = nst;
            q.push_back(e);
        end
        m_state = nst;

        // a key counts as released-after-reset once a real sample shows it high
        if (cyc >= 3) m_armed = m_armed | hist_k[$-1];
        // accepted level flips after WIN consecutive samples differing from it
        newpress = 4'h0;
        for (int k = 0; k < 4; k++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= WIN; j++) begin
                h = hist_k[$-j];
                if (h[k] == m_deb[k]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_deb[k] = ~m_deb[k];
                if (!m_deb[k] && m_armed[k]) newpress[k] = 1'b1;
            end
        end
        m_press = newpress;
        hist_k.push_back(key_n);
        hist_sw.push_back(sw);
        if (hist_k.size() > 32) begin
            void'(hist_k.pop_front());
            void'(hist_sw.pop_front());
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("state", {30'd0, o_state}, {30'd0, m_state});
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL missed_event: got none at cycle %0d, expected %h", e.cyc, e.ev);
                end
                if (o_event != 16'h0) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_event: got %h at cycle %0d, expected none", o_event, cyc);
                    end else begin
                        e = q.pop_front();
                        check("event_word",  {16'd0, o_event}, {16'd0, e.ev});
                        check("event_cycle", cyc, e.cyc);
                        check("event_state", {30'd0, o_state}, {30'd0, e.st});
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ev(input string name, output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (o_event != 16'h0) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event in 40 cycles, expected one", name);
    endtask

    task automatic no_ev(input string name, input int n);
        logic [15:0] seen;
        seen = 16'h0;
        repeat (n) begin
            @(negedge clk);
            if (o_event != 16'h0) seen = o_event;
        end
        check(name, {16'd0, seen}, 32'd0);
    endtask

    task automatic press_expect(input string name, input logic [3:0] mask,
                                input logic [3:0] code, input logic [1:0] st);
        int lat;
        key_n = ~mask;
        wait_ev(name, lat);
        check({name, "_code"},  {28'd0, o_event[15:12]}, {28'd0, code});
        check({name, "_state"}, {30'd0, o_state}, {30'd0, st});
        hold(4);
        key_n = 4'hF;
        hold(WIN + 6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int         lat;
        int         hold_n;
        logic [3:0] mask;

        hold(3);
        check("reset_event", {16'd0, o_event}, 32'd0);
        check("reset_state", {30'd0, o_state}, 32'd0);
        rst_n = 1'b1;
        hold(5);

        // first press: PLAY from IDLE with sw = 1_01_0110
        sw    = 7'b1_01_0110;
        hold(3);
        key_n = 4'b1101;
        wait_ev("first_press", lat);
        check("first_event",   {16'd0, o_event}, 32'h25A0);
        check("first_state",   {30'd0, o_state}, {30'd0, ST_PLAY});
        check("first_latency", lat, 3 + WIN);
        @(negedge clk);
        check("single_cycle", {16'd0, o_event}, 32'd0);
        hold(10 - lat - 1);
        key_n = 4'hF;
        hold(WIN + 6);

        // PLAY/PAUSE toggling and STOP
        press_expect("pause",   4'b0010, 4'd3, ST_PAUSE);
        press_expect("resume",  4'b0010, 4'd2, ST_PLAY);
        press_expect("stop",    4'b0100, 4'd4, ST_IDLE);
        press_expect("speed",   4'b1000, 4'd5, ST_IDLE);

        // short glitch on RECORD
        key_n = 4'b1110;
        hold(3);
        key_n = 4'hF;
`ifdef KEY_DEBOUNCE_EN
        no_ev("glitch_event", 15);
        check("glitch_state", {30'd0, o_state}, {30'd0, ST_IDLE});
`else
        wait_ev("glitch_press", lat);
        check("glitch_code",  {28'd0, o_event[15:12]}, 32'd1);
        check("glitch_state", {30'd0, o_state}, {30'd0, ST_REC});
        hold(WIN + 6);
`endif
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        hold(3);

        // simultaneous STOP + PLAY in RECORDING
        press_expect("record",   4'b0001, 4'd1, ST_REC);
        press_expect("stop_win", 4'b0110, 4'd4, ST_IDLE);
        press_expect("record2",  4'b0001, 4'd1, ST_REC);

        // same again with i_stop in the decision cycle
        key_n = 4'b1001;
        hold(2 + WIN);
        stop = 1'b1;
        @(negedge clk);
        check("stop_prio_event", {16'd0, o_event}, 32'd0);
        stop = 1'b0;
        no_ev("stop_prio_after", 10);
        check("stop_prio_state", {30'd0, o_state}, {30'd0, ST_IDLE});
        key_n = 4'hF;
        hold(WIN + 6);

        // RECORD held through reset release
        key_n = 4'b1110;
        rst_n = 1'b0;
        hold(3);
        rst_n = 1'b1;
        no_ev("held_reset_event", 20);
        check("held_reset_state", {30'd0, o_state}, {30'd0, ST_IDLE});
        key_n = 4'hF;
        hold(WIN + 6);
        press_expect("rearm", 4'b0001, 4'd1, ST_REC);

        // asynchronous reset in the middle of a debounce
        key_n = 4'b1011;
        hold(2);
        check("pre_async_state", {30'd0, o_state}, {30'd0, ST_REC});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_event", {16'd0, o_event}, 32'd0);
        check("async_rst_state", {30'd0, o_state}, 32'd0);
        @(negedge clk);
        hold(2);
        key_n = 4'hF;
        rst_n = 1'b1;
        hold(10);

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            sw = 7'($urandom);
            if ($urandom_range(0, 1) == 0) mask = 4'b0001 << $urandom_range(0, 3);
            else                           mask = 4'($urandom_range(1, 15));
            key_n  = ~mask;
            hold_n = $urandom_range(1, WIN + 8);
            for (int c = 0; c < hold_n; c++) begin
                stop = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
            stop   = 1'b0;
            key_n  = 4'hF;
            hold_n = $urandom_range(1, WIN + 8);
            for (int c = 0; c < hold_n; c++) begin
                stop = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
            stop = 1'b0;
        end

        hold(20);
        check("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
